// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin arbiter sharing one external ALU between two requesters
module alu_arbiter #(
  parameter int EXEC_CYCLES = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       req0,
  input  logic       req1,
  input  logic [2:0] op0,
  input  logic [2:0] op1,
  input  logic [3:0] a0,
  input  logic [3:0] b0,
  input  logic [3:0] a1,
  input  logic [3:0] b1,
  output logic       gnt0,
  output logic       gnt1,
  output logic [2:0] alu_sel,
  output logic [7:0] alu_in,
  input  logic [7:0] alu_out,
  output logic [7:0] result,
  output logic       result_id,
  output logic       done,
  output logic       err,
  output logic       busy
);
  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;
  state_t state_q, state_d;
  logic ptr_q, ptr_d, id_q, id_d, win1, illegal;
  logic [3:0] cnt_q, cnt_d;
  logic gnt0_q, gnt0_d, gnt1_q, gnt1_d, done_q, done_d, err_q, err_d, busy_q, busy_d;
  logic result_id_q, result_id_d;
  logic [2:0] alu_sel_q, alu_sel_d;
  logic [7:0] alu_in_q, alu_in_d, result_q, result_d;
  assign win1 = req1 & (~req0 | ptr_q);
  assign illegal = &alu_sel_q[2:1];
  // alu_sel_q/alu_in_q double as the latched op and operands for the whole EXEC phase
  always_comb begin
    state_d = state_q;
    ptr_d = ptr_q;
    id_d = id_q;
    cnt_d = cnt_q;
    gnt0_d = 1'b0;
    gnt1_d = 1'b0;
    done_d = 1'b0;
    err_d = 1'b0;
    alu_sel_d = alu_sel_q;
    alu_in_d = alu_in_q;
    result_d = result_q;
    result_id_d = result_id_q;
    case (state_q)
      IDLE: if (req0 | req1) begin
        state_d = EXEC;
        id_d = win1;
        ptr_d = ~win1;
        gnt0_d = ~win1;
        gnt1_d = win1;
        alu_sel_d = win1 ? op1 : op0;
        alu_in_d = win1 ? {a1, b1} : {a0, b0};
        cnt_d = 4'(EXEC_CYCLES - 1);
      end
      EXEC: if (cnt_q == 4'd0) begin
        state_d = DONE;
        result_d = illegal ? 8'h00 : alu_out;
        result_id_d = id_q;
        done_d = 1'b1;
        err_d = illegal;
        alu_sel_d = 3'd0;
        alu_in_d = 8'h00;
      end else cnt_d = cnt_q - 4'd1;
      default: state_d = IDLE;
    endcase
    busy_d = state_d != IDLE;
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      ptr_q <= 1'b0;
      id_q <= 1'b0;
      cnt_q <= 4'd0;
      gnt0_q <= 1'b0;
      gnt1_q <= 1'b0;
      done_q <= 1'b0;
      err_q <= 1'b0;
      busy_q <= 1'b0;
      alu_sel_q <= 3'd0;
      alu_in_q <= 8'h00;
      result_q <= 8'h00;
      result_id_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      id_q <= id_d;
      cnt_q <= cnt_d;
      gnt0_q <= gnt0_d;
      gnt1_q <= gnt1_d;
      done_q <= done_d;
      err_q <= err_d;
      busy_q <= busy_d;
      alu_sel_q <= alu_sel_d;
      alu_in_q <= alu_in_d;
      result_q <= result_d;
      result_id_q <= result_id_d;
    end
  end
  assign gnt0 = gnt0_q;
  assign gnt1 = gnt1_q;
  assign done = done_q;
  assign err = err_q;
  assign busy = busy_q;
  assign alu_sel = alu_sel_q;
  assign alu_in = alu_in_q;
  assign result = result_q;
  assign result_id = result_id_q;
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed and random checks of alu_arbiter against a transaction-level model
module tb_alu_arbiter;
  localparam int E = 2;
  logic clk = 1'b0, reset_n = 1'b0, req0 = 1'b0, req1 = 1'b0;
  logic [2:0] op0 = '0, op1 = '0, alu_sel;
  logic [3:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
  logic gnt0, gnt1, result_id, done, err, busy;
  logic [7:0] alu_in, alu_out, result;
  int errors = 0, checks = 0;
  // transaction model: m_pos counts cycles since the grant of the active operation
  bit m_act = 0, m_ptr = 0, m_id = 0, m_rid = 0;
  int m_pos = 0;
  logic [2:0] m_op = '0;
  logic [3:0] m_a = '0, m_b = '0;
  logic [7:0] m_res = '0;

  alu_arbiter #(.EXEC_CYCLES(E)) dut (
    .clk(clk), .reset_n(reset_n), .req0(req0), .req1(req1), .op0(op0), .op1(op1),
    .a0(a0), .b0(b0), .a1(a1), .b1(b1), .gnt0(gnt0), .gnt1(gnt1), .alu_sel(alu_sel),
    .alu_in(alu_in), .alu_out(alu_out), .result(result), .result_id(result_id),
    .done(done), .err(err), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] alu_f(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
    case (op)
      3'd0, 3'd1: return {4'h0, a} + {4'h0, b};
      3'd2: return {a | b, a ^ b};
      3'd3: return {7'd0, |{a, b}};
      3'd4: return {7'd0, &{a, b}};
      3'd5: return {a, b};
      default: return 8'hFF;
    endcase
  endfunction

  assign alu_out = alu_f(alu_sel, alu_in[7:4], alu_in[3:0]);

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic model_step();
    bit w;
    if (!reset_n) begin
      m_act = 0; m_ptr = 0; m_pos = 0; m_res = 8'h00; m_rid = 0;
    end else if (m_act) begin
      m_pos++;
      if (m_pos == E) begin
        m_res = (m_op >= 3'd6) ? 8'h00 : alu_f(m_op, m_a, m_b);
        m_rid = m_id;
      end
      if (m_pos == E + 1) m_act = 0;
    end else if (req0 || req1) begin
      w = (req0 && req1) ? m_ptr : req1;
      m_id = w; m_ptr = !w; m_act = 1; m_pos = 0;
      m_op = w ? op1 : op0;
      m_a = w ? a1 : a0;
      m_b = w ? b1 : b0;
    end
  endtask

  task automatic cycle();
    bit ex, dn;
    @(posedge clk);
    model_step();
    #1;
    ex = m_act && m_pos < E;
    dn = m_act && m_pos == E;
    chk("gnt0", {7'd0, gnt0}, {7'd0, m_act && m_pos == 0 && !m_id});
    chk("gnt1", {7'd0, gnt1}, {7'd0, m_act && m_pos == 0 && m_id});
    chk("busy", {7'd0, busy}, {7'd0, m_act});
    chk("done", {7'd0, done}, {7'd0, dn});
    chk("err", {7'd0, err}, {7'd0, dn && m_op >= 3'd6});
    chk("alu_sel", {5'd0, alu_sel}, ex ? {5'd0, m_op} : 8'h00);
    chk("alu_in", alu_in, ex ? {m_a, m_b} : 8'h00);
    chk("result", result, m_res);
    chk("result_id", {7'd0, result_id}, {7'd0, m_rid});
  endtask

  initial begin
    repeat (2) cycle();
    chk("rst_busy", {7'd0, busy}, 8'h00);
    reset_n = 1'b1;
    req0 = 1; op0 = 3'b001; a0 = 4'd5; b0 = 4'd3;
    cycle();
    chk("t1_gnt0", {7'd0, gnt0}, 8'h01);
    req0 = 0;
    repeat (E) cycle();
    chk("t1_done", {7'd0, done}, 8'h01);
    chk("t1_res", result, 8'h08);
    chk("t1_id", {7'd0, result_id}, 8'h00);
    cycle();
    req1 = 1; op1 = 3'b010; a1 = 4'hC; b1 = 4'hA;
    cycle();
    req1 = 0;
    chk("t2_in", alu_in, 8'hCA);
    repeat (E) cycle();
    chk("t2_res", result, 8'hE6);
    chk("t2_id", {7'd0, result_id}, 8'h01);
    cycle();
    req0 = 1; op0 = 3'b111;
    cycle();
    req0 = 0;
    repeat (E) cycle();
    chk("t3_done", {7'd0, done}, 8'h01);
    chk("t3_res", result, 8'h00);
    chk("t3_err", {7'd0, err}, 8'h01);
    cycle();
    chk("t3_err_clr", {7'd0, err}, 8'h00);
    reset_n = 0; req0 = 1; req1 = 1; op0 = 3'b000; op1 = 3'b101;
    cycle();
    reset_n = 1;
    cycle();
    chk("t4_first", {6'd0, gnt1, gnt0}, 8'h01);
    repeat (E + 2) cycle();
    chk("t4_second", {6'd0, gnt1, gnt0}, 8'h02);
    repeat (E + 2) cycle();
    chk("t4_third", {6'd0, gnt1, gnt0}, 8'h01);
    req0 = 0; req1 = 0;
    repeat (E + 2) cycle();
    req0 = 1; op0 = 3'b001; a0 = 4'hF; b0 = 4'hF;
    cycle();
    req0 = 0; reset_n = 0;
    cycle();
    chk("t5_busy", {7'd0, busy}, 8'h00);
    reset_n = 1;
    repeat (E + 2) cycle();
    chk("t5_res", result, 8'h00);
    req1 = 1;
    cycle();
    chk("t5_gnt1", {6'd0, gnt1, gnt0}, 8'h02);
    req1 = 0;
    repeat (E + 2) cycle();
    reset_n = 0;
    cycle();
    reset_n = 1; req0 = 1; req1 = 1;
    cycle();
    chk("t5_both", {6'd0, gnt1, gnt0}, 8'h01);
    for (int i = 0; i < 600; i++) begin
      reset_n = $urandom_range(0, 39) != 0;
      req0 = $urandom_range(0, 1) == 1;
      req1 = $urandom_range(0, 1) == 1;
      op0 = 3'($urandom); op1 = 3'($urandom);
      a0 = 4'($urandom); b0 = 4'($urandom);
      a1 = 4'($urandom); b1 = 4'($urandom);
      cycle();
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
